// File: rtl/mem_access_unit.sv
// Multi-cycle memory access unit: launches one fetch, read or write per request,
// holds the controller with stall, and reports misalignment and timeouts on a sticky fault.
module mem_access_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IorD,
  input  logic [31:0] PC,
  input  logic [31:0] ALUOut,
  input  logic [31:0] B,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        IRWrite,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] Instr,
  output logic [5:0]  Opcode,
  output logic [5:0]  Funct,
  output logic [31:0] Data,
  output logic        stall,
  output logic        fault
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
  typedef enum logic [1:0] {OP_FETCH, OP_READ, OP_WRITE} op_e;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] data_q, data_d;
  logic        fault_q, fault_d;

  logic        req_any;
  logic [31:0] req_addr;

  assign req_any  = MemRead | MemWrite | IRWrite;
  assign req_addr = IorD ? ALUOut : PC;

  // Handshake: mem_req stays high through BUSY with address/data frozen; the
  // access completes on the first BUSY cycle that sees mem_ready high.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    instr_d = instr_q;
    data_d  = data_q;
    fault_d = fault_q;
    stall   = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          stall   = 1'b1;
          addr_d  = req_addr;
          wdata_d = B;
          cnt_d   = 8'd0;
          if (MemWrite)     op_d = OP_WRITE;
          else if (IRWrite) op_d = OP_FETCH;
          else              op_d = OP_READ;
          // Misaligned accesses never reach memory.
          if (req_addr[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        mem_we  = (op_q == OP_WRITE);
        if (mem_ready) begin
          if (op_q == OP_FETCH) instr_d = mem_rdata;
          if (op_q == OP_READ)  data_d  = mem_rdata;
          state_d = S_DONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          fault_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_FETCH;
      cnt_q   <= 8'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      instr_q <= 32'd0;
      data_q  <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      instr_q <= instr_d;
      data_q  <= data_d;
      fault_q <= fault_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign Instr     = instr_q;
  assign Opcode    = instr_q[31:26];
  assign Funct     = instr_q[5:0];
  assign Data      = data_q;
  assign fault     = fault_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: TIMEOUT, default 15, max mem_ready wait cycles before an access aborts (range 1..255).
REQ-002 Ports (clk and rst first), one per line:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset; synchronous and active-high.
- IorD  in  1  address select from controller: 0 = PC, 1 = ALUOut.
- PC  in  32  fetch address.
- ALUOut  in  32  data address.
- B  in  32  store data.
- MemRead  in  1  controller requests a data read.
- MemWrite  in  1  controller requests a data write.
- IRWrite  in  1  controller requests an instruction fetch.
- mem_rdata  in  32  memory read data; valid when mem_ready=1.
- mem_ready  in  1  memory completes the current access.
- mem_req  out  1  access in progress toward memory.
- mem_we  out  1  current access is a write.
- mem_addr  out  32  latched access address.
- mem_wdata  out  32  latched store data.
- Instr  out  32  instruction register.
- Opcode  out  6  Instr[31:26], to control unit.
- Funct  out  6  Instr[5:0], to control unit.
- Data  out  32  memory data register.
- stall  out  1  controller holds its state while 1.
- fault  out  1  sticky: misaligned address or timeout.

Function
REQ-003 FSM states: IDLE, BUSY, DONE; encoding free.
REQ-004 IDLE with any of MemRead/MemWrite/IRWrite = 1: latch addr (IorD ? ALUOut : PC), B, op type; go to BUSY; stall = 1 combinationally in that same cycle.
REQ-005 Priority on simultaneous requests: MemWrite > IRWrite > MemRead; only one access launched.
REQ-006 Address with [1:0] != 0: no access issued, fault set, go to DONE directly; Instr/Data unchanged.
REQ-007 BUSY: mem_req = 1, mem_we = 1 only for writes, mem_addr/mem_wdata stable for the whole access.
REQ-008 BUSY with mem_ready = 1: fetch loads Instr <= mem_rdata, read loads Data <= mem_rdata, write loads neither; go to DONE.
REQ-009 Wait counter clears on BUSY entry, increments per BUSY cycle with mem_ready = 0; on reaching TIMEOUT, set fault, drop mem_req, go to DONE.
REQ-010 DONE: stall = 0, mem_req = 0, one cycle, then IDLE; a request present in DONE is ignored.
REQ-011 Latency: request at cycle N, mem_ready at N+k (k >= 1) -> stall low at N+k+1, Instr/Data valid from N+k+1.
REQ-012 Instr holds between fetches; Opcode/Funct derived combinationally from Instr only.
REQ-013 fault is sticky until rst; it does not block later accesses.
REQ-014 mem_ready outside BUSY is ignored.

Reset
REQ-015 rst = 1 at a clock edge: state IDLE, counter 0, Instr = 0, Data = 0, mem_addr = 0, mem_wdata = 0, fault = 0; mem_req, mem_we, stall = 0.
REQ-016 rst mid-BUSY aborts the access: mem_req = 0 next cycle, no register update from mem_rdata.

Verification
REQ-017 Fetch: IorD=0, PC=0x00000004, IRWrite=1, mem_ready after 2 cycles with rdata 0x012A4020 -> Instr=0x012A4020, Opcode=0x00, Funct=0x20, stall low 3 cycles after request.
REQ-018 Store: IorD=1, ALUOut=0x00000010, B=0xDEADBEEF, MemWrite=1 -> mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF until mem_ready; Instr/Data unchanged.
REQ-019 Misaligned: IorD=1, ALUOut=0x00000006, MemRead=1 -> mem_req never 1, fault=1, stall high exactly 1 cycle.
REQ-020 Timeout: TIMEOUT=15, fetch with mem_ready held 0 -> fault=1 after 15 BUSY cycles, stall released, Instr still 0.
REQ-021 Priority: MemWrite=1 and IRWrite=1 in same IDLE cycle -> write issued (mem_we=1), Instr not loaded.
REQ-022 Reset mid-access: rst=1 during BUSY -> next cycle all outputs at REQ-015 values; later mem_ready=1 with rdata 0xFFFFFFFF leaves Data=0.
